flash_fetch_cache: RTL and testbench
====================================

# flash_fetch_cache

Direct-mapped, read-only word cache between the CPU's instruction/data read port and the SPI flash controller. CPU reads that hit return in one cycle with no busy. Misses issue a single-word read strobe to the flash controller, wait for it to finish, fill the line and return the word. This cuts the ~64-cycle SPI round trip out of tight loops executing from flash.

## Interface
- `INDEX_BITS`, default 4: cache index width, giving 2^INDEX_BITS one-word lines. Legal range is 1–8. The tag width is 15−INDEX_BITS.
- `clk` in 1: system clock, 25 MHz. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_rstrb` in 1: CPU read strobe, one-cycle pulse.
- `mem_word_address` in 15: CPU word address. Sampled only with `mem_rstrb`.
- `mem_rdata` out 32: read data. Valid while `mem_rbusy`=0 following a strobe.
- `mem_rbusy` out 1: high while a miss is outstanding.
- `flash_rstrb` out 1: read strobe to the flash controller, one-cycle pulse.
- `flash_word_address` out 15: word address to the flash controller.
- `flash_rdata` in 32: word from the flash controller. Already byte-ordered.
- `flash_rbusy` in 1: flash controller busy (chip select asserted).
- `flush` in 1: synchronous invalidate of all lines.

## Operation
- Storage per line: `valid` (1), `tag` (15−INDEX_BITS), `data` (32).
  - `index = mem_word_address[INDEX_BITS-1:0]`
  - `tag = mem_word_address[14:INDEX_BITS]`
- FSM states: IDLE, REQ, ARM, WAIT, FILL.
- **IDLE**, when `mem_rstrb`=1:
  - The address is latched.
  - On a hit (valid and tag match), `mem_rdata` gets the line data next cycle, `mem_rbusy` stays 0, and the FSM stays in IDLE.
  - On a miss, go to REQ. `mem_rbusy`=1 from the next cycle.
- **REQ**: `flash_rstrb`=1 for exactly this cycle. `flash_word_address` = latched address, held constant until FILL exits. Go to ARM.
- **ARM**: one cycle. `flash_rbusy` is ignored here, because the controller raises it on the falling edge after the strobe. Go to WAIT.
- **WAIT**: stay until `flash_rbusy`=0, then go to FILL.
- **FILL**:
  - Write `flash_rdata`, the tag and `valid`=1 into the line.
  - `mem_rdata` gets `flash_rdata`, and `mem_rbusy` drops to 0 on the following cycle.
  - Return to IDLE.
- `mem_rstrb` while not in IDLE is ignored, with no queueing. The CPU must wait for `mem_rbusy`=0.
- `flush` in IDLE clears every `valid` bit next cycle. A strobe in the same cycle as `flush` is treated as a miss.
- `flush` in any other state is held pending and applied on the FILL→IDLE transition, after the fill is written.
- Reset:
  - All `valid`=0; state=IDLE.
  - `mem_rbusy`=0, `flash_rstrb`=0, `flash_word_address`=0, `mem_rdata`=0.
  - Reset mid-miss abandons the request. The flash controller finishes its transfer on its own and the result is discarded.

## Timing
- Hit latency: strobe at edge N, data at edge N+1, `mem_rbusy` never asserted.
- Miss latency: strobe at edge N, then:
  - REQ at N+1, ARM at N+2, WAIT from N+3.
  - FILL is the cycle after `flash_rbusy` is first seen low.
  - Data is valid and `mem_rbusy`=0 one cycle after FILL.
  - With the 64-bit SPI transaction this totals about 68 cycles.
- `flash_rstrb` is never asserted in two consecutive cycles.
- `mem_rdata` holds its last value until the next hit or fill.

## Configuration
- `FLASH_CACHE_STATS_EN` defined: adds outputs `hit_count` [15:0] and `miss_count` [15:0].
  - Each counts accepted strobes (IDLE only) and saturates at 16'hFFFF.
  - Both reset to 0 and are cleared by `flush`.
- Not defined: those ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Cold miss:** reset, then strobe address 0x0010 with the flash model returning 0xDEADBEEF.
  - Exactly one `flash_rstrb` with `flash_word_address`=0x0010.
  - `mem_rdata`=0xDEADBEEF with `mem_rbusy`=0.
- **Hit:** repeat address 0x0010 with the flash model armed to fail if strobed.
  - Data 0xDEADBEEF one cycle after the strobe.
  - `mem_rbusy` stays 0 and no `flash_rstrb`.
- **Conflict eviction** (INDEX_BITS=4): read 0x0003 (returns 0x11111111), then 0x0013 (returns 0x22222222), then 0x0003 again.
  - Three flash requests in total.
  - Last `mem_rdata`=0x11111111.
- **Flush mid-miss:** pulse `flush` while in WAIT for 0x0020.
  - The fill completes and data is returned.
  - A following strobe to 0x0020 misses again.
- **Async reset mid-miss:** assert `reset` during WAIT.
  - `mem_rbusy`=0 immediately.
  - After release, 0x0010 misses.
  - A strobe ignored while busy causes no second `flash_rstrb`.
- **Stats** (with `FLASH_CACHE_STATS_EN`): perform 3 misses and 5 hits.
  - `miss_count`=3, `hit_count`=5.
  - Both read 0 after `flush`.

Source files
------------

// File: rtl/flash_fetch_cache.sv
// flash_fetch_cache
//   Direct-mapped, read-only, one-word-per-line cache between the CPU read port and the
//   SPI flash controller. Hits return data the cycle after the strobe without raising
//   mem_rbusy. Misses issue a single flash read, wait for it, fill the line and return
//   the word.
//
// Parameters
//   INDEX_BITS          index width (1..8), 2^INDEX_BITS lines, tag is 15-INDEX_BITS bits
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   mem_rstrb           CPU read strobe (one-cycle pulse)
//   mem_word_address    CPU word address, sampled with mem_rstrb
//   mem_rdata           read data, valid while mem_rbusy=0 after a strobe
//   mem_rbusy           high while a miss is outstanding
//   flash_rstrb         read strobe to the flash controller
//   flash_word_address  word address to the flash controller
//   flash_rdata         word returned by the flash controller
//   flash_rbusy         flash controller busy
//   flush               synchronous invalidate of all lines
//   hit_count,
//   miss_count          saturating strobe counters (only with FLASH_CACHE_STATS_EN)
//
// Configuration
//   FLASH_CACHE_STATS_EN  when defined, adds the hit_count/miss_count outputs.

module flash_fetch_cache #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rstrb,
   input  logic [14:0] mem_word_address,
   output logic [31:0] mem_rdata,
   output logic        mem_rbusy,
   output logic        flash_rstrb,
   output logic [14:0] flash_word_address,
   input  logic [31:0] flash_rdata,
   input  logic        flash_rbusy,
   input  logic        flush
`ifdef FLASH_CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int unsigned TagBits = 15 - INDEX_BITS;
   localparam int unsigned Lines   = 2 ** INDEX_BITS;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StArm,
      StWait,
      StFill
   } state_e;

   state_e state_q, state_d;

   logic [Lines-1:0]   valid_q;
   logic [TagBits-1:0] tag_mem  [Lines];
   logic [31:0]        data_mem [Lines];

   logic [14:0] addr_q;
   logic [31:0] rdata_q;
   logic        flush_pend_q;

   logic [INDEX_BITS-1:0] req_idx;
   logic [TagBits-1:0]    req_tag;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TagBits-1:0]    fill_tag;
   logic                  accept;
   logic                  hit;

   assign req_idx  = mem_word_address[INDEX_BITS-1:0];
   assign req_tag  = mem_word_address[14:INDEX_BITS];
   assign fill_idx = addr_q[INDEX_BITS-1:0];
   assign fill_tag = addr_q[14:INDEX_BITS];

   assign accept = (state_q == StIdle) && mem_rstrb;
   // A strobe coinciding with flush must not hit on a line that is being invalidated.
   assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

   // ---------------------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flash_rstrb = 1'b0;
      mem_rbusy   = 1'b1;
      unique case (state_q)
         StIdle: begin
            mem_rbusy = 1'b0;
            if (accept && !hit) begin
               state_d = StReq;
            end
         end
         StReq: begin
            flash_rstrb = 1'b1;
            state_d     = StArm;
         end
         // The controller raises flash_rbusy only after it has seen the strobe, so its
         // value here is stale.
         StArm: begin
            state_d = StWait;
         end
         StWait: begin
            if (!flash_rbusy) begin
               state_d = StFill;
            end
         end
         StFill: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Valid bits and deferred flush
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         if (state_q == StIdle) begin
            if (flush) begin
               valid_q <= '0;
            end
         end else if (state_q == StFill) begin
            // A flush seen during the miss wins over the line just filled.
            if (flush_pend_q || flush) begin
               valid_q <= '0;
            end else begin
               valid_q[fill_idx] <= 1'b1;
            end
            flush_pend_q <= 1'b0;
         end else if (flush) begin
            flush_pend_q <= 1'b1;
         end
      end
   end

   // Tag and data storage need no reset: a line is only read when its valid bit is set.
   always_ff @(posedge clk) begin
      if (state_q == StFill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= flash_rdata;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Address latch and read data
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= mem_word_address;
         end
         if (accept && hit) begin
            rdata_q <= data_mem[req_idx];
         end else if (state_q == StFill) begin
            rdata_q <= flash_rdata;
         end
      end
   end

   assign mem_rdata          = rdata_q;
   assign flash_word_address = addr_q;

`ifdef FLASH_CACHE_STATS_EN
   // ---------------------------------------------------------------------------------------
   // Saturating hit/miss counters; flush clears them and takes priority over counting.
   // ---------------------------------------------------------------------------------------
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (flush) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (accept) begin
         if (hit) begin
            if (hit_cnt_q != 16'hFFFF) begin
               hit_cnt_q <= hit_cnt_q + 16'd1;
            end
         end else if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_flash_fetch_cache.sv
// tb_flash_fetch_cache
//   Scoreboard bench: the driver pushes the expected word and latency of every accepted
//   strobe; a monitor accepts strobes when the DUT is idle and pops/compares when
//   mem_rbusy is low on a later falling edge. A behavioural flash controller answers
//   strobes after BusyCyc cycles of flash_rbusy.

module tb_flash_fetch_cache;

   localparam int BusyCyc = 10;
   localparam int MissLat = BusyCyc + 4;  // falling edges from acceptance to data
   localparam int HitLat  = 1;

   logic        clk;
   logic        reset;
   logic        mem_rstrb;
   logic [14:0] mem_word_address;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        flash_rstrb;
   logic [14:0] flash_word_address;
   logic [31:0] flash_rdata;
   logic        flash_rbusy;
   logic        flush;
`ifdef FLASH_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   flash_fetch_cache #(
      .INDEX_BITS(4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .mem_rstrb         (mem_rstrb),
      .mem_word_address  (mem_word_address),
      .mem_rdata         (mem_rdata),
      .mem_rbusy         (mem_rbusy),
      .flash_rstrb       (flash_rstrb),
      .flash_word_address(flash_word_address),
      .flash_rdata       (flash_rdata),
      .flash_rbusy       (flash_rbusy),
      .flush             (flush)
`ifdef FLASH_CACHE_STATS_EN
      ,
      .hit_count         (hit_count),
      .miss_count        (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          lat;    // negative: latency not checked
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          nstrobes = 0;
   logic [14:0] exp_faddr = '0;
   logic        pending = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] flash_word(input logic [14:0] a);
      case (a)
         15'h0010: flash_word = 32'hDEADBEEF;
         15'h0003: flash_word = 32'h11111111;
         15'h0013: flash_word = 32'h22222222;
         15'h0020: flash_word = 32'hCAFEF00D;
         default:  flash_word = 32'hA5A50000 | {17'd0, a};
      endcase
   endfunction

   // Monitor: accept strobes seen while idle, compare when the response is presented.
   initial begin : monitor
      int   negc;
      int   acc;
      exp_t e;
      negc = 0;
      acc  = 0;
      forever begin
         @(negedge clk);
         negc++;
         if (pending && !mem_rbusy) begin
            pending = 1'b0;
            if (sb_q.size() == 0) begin
               check("unexpected_response", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rdata", mem_rdata, e.data);
               if (e.lat >= 0) check("latency", negc - acc, e.lat);
            end
         end
         if (!pending && mem_rstrb && !mem_rbusy && !reset) begin
            pending = 1'b1;
            acc     = negc;
         end
      end
   end

   // Flash controller model: busy raised on the falling edge after the strobe is sampled.
   initial begin : flash_model
      logic [14:0] a;
      flash_rbusy = 1'b0;
      flash_rdata = '0;
      forever begin
         @(negedge clk);
         if (flash_rstrb) begin
            nstrobes++;
            a = flash_word_address;
            check("flash_addr", {17'd0, a}, {17'd0, exp_faddr});
            @(negedge clk);
            check("flash_rstrb_single", {31'd0, flash_rstrb}, 32'd0);
            flash_rbusy = 1'b1;
            repeat (BusyCyc) @(negedge clk);
            flash_rdata = flash_word(a);
            flash_rbusy = 1'b0;
         end
      end
   end

   task automatic issue(input logic [14:0] addr, input logic miss);
      exp_t e;
      e.data = flash_word(addr);
      e.lat  = miss ? MissLat : HitLat;
      sb_q.push_back(e);
      if (miss) exp_faddr = addr;
      @(posedge clk); #1;
      mem_rstrb        = 1'b1;
      mem_word_address = addr;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || pending) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0 || pending) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no response expected response within 200 cycles", name);
         sb_q.delete();
         pending = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic rd(input string name, input logic [14:0] addr, input logic miss);
      int s;
      s = nstrobes;
      issue(addr, miss);
      wait_done(name);
      check({name, "_flash_reqs"}, nstrobes - s, miss ? 1 : 0);
   endtask

   initial begin : watchdog
      #(40 * 20000);
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin : stim
      exp_t e;
      int   s;
      reset            = 1'b1;
      mem_rstrb        = 1'b0;
      mem_word_address = '0;
      flush            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rbusy", {31'd0, mem_rbusy}, 32'd0);
      check("reset_flash_rstrb", {31'd0, flash_rstrb}, 32'd0);
      check("reset_flash_addr", {17'd0, flash_word_address}, 32'd0);
      check("reset_rdata", mem_rdata, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Cold miss, then hit on the same word.
      rd("cold_miss", 15'h0010, 1'b1);
      rd("hit", 15'h0010, 1'b0);

      // Conflict eviction on index 3.
      s = nstrobes;
      rd("conflict_a", 15'h0003, 1'b1);
      rd("conflict_b", 15'h0013, 1'b1);
      rd("conflict_a2", 15'h0003, 1'b1);
      check("conflict_total_reqs", nstrobes - s, 3);
      rd("other_index_hit", 15'h0010, 1'b0);

      // Flush while waiting on flash: fill still returns, then everything misses.
      issue(15'h0020, 1'b1);
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_done("flush_mid");
      rd("after_flush_0020", 15'h0020, 1'b1);
      rd("after_flush_0010", 15'h0010, 1'b1);

      // Strobe together with flush in idle counts as a miss.
      s = nstrobes;
      e.data = flash_word(15'h0010);
      e.lat  = MissLat;
      sb_q.push_back(e);
      exp_faddr = 15'h0010;
      @(posedge clk); #1;
      mem_rstrb        = 1'b1;
      mem_word_address = 15'h0010;
      flush            = 1'b1;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
      flush     = 1'b0;
      wait_done("strobe_with_flush");
      check("strobe_with_flush_reqs", nstrobes - s, 1);
      rd("refilled_hit", 15'h0010, 1'b0);

      // Async reset mid-miss, with an ignored strobe while busy beforehand.
      s = nstrobes;
      e.data = 32'd0;
      e.lat  = -1;
      sb_q.push_back(e);
      exp_faddr = 15'h0030;
      @(posedge clk); #1;
      mem_rstrb        = 1'b1;
      mem_word_address = 15'h0030;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
      @(posedge clk); #1;
      mem_rstrb        = 1'b1;
      mem_word_address = 15'h0031;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
      @(posedge clk); #1;
      check("busy_before_reset", {31'd0, mem_rbusy}, 32'd1);
      reset = 1'b1;
      #1;
      check("reset_async_rbusy", {31'd0, mem_rbusy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      wait_done("reset_mid");
      check("ignored_strobe_reqs", nstrobes - s, 1);
      repeat (BusyCyc + 4) @(posedge clk);
      rd("after_reset_miss", 15'h0010, 1'b1);

`ifdef FLASH_CACHE_STATS_EN
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      rd("st_m0", 15'h0040, 1'b1);
      rd("st_m1", 15'h0041, 1'b1);
      rd("st_m2", 15'h0042, 1'b1);
      rd("st_h0", 15'h0040, 1'b0);
      rd("st_h1", 15'h0041, 1'b0);
      rd("st_h2", 15'h0042, 1'b0);
      rd("st_h3", 15'h0040, 1'b0);
      rd("st_h4", 15'h0041, 1'b0);
      check("miss_count", {16'd0, miss_count}, 32'd3);
      check("hit_count", {16'd0, hit_count}, 32'd5);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      check("miss_count_flushed", {16'd0, miss_count}, 32'd0);
      check("hit_count_flushed", {16'd0, hit_count}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
